// File: rtl/pico_mem_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory port among NUM_REQ cores.
// Optional watchdog: define PICO_MEM_ARB_TIMEOUT_EN (adds the timeout_err port).
module pico_mem_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_instr,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*32-1:0]      req_addr,
    input  logic [NUM_REQ*32-1:0]      req_wdata,
    input  logic [NUM_REQ*4-1:0]       req_wstrb,
    output logic [31:0]                req_rdata,
    output logic                       dn_valid,
    output logic                       dn_instr,
    input  logic                       dn_ready,
    output logic [31:0]                dn_addr,
    output logic [31:0]                dn_wdata,
    output logic [3:0]                 dn_wstrb,
    input  logic [31:0]                dn_rdata,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
`ifdef PICO_MEM_ARB_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t         r_state, w_next;
    logic [IDW-1:0] r_grant, r_rr_ptr, w_sel;
    logic           w_any, w_done, w_timeout;
    logic [31:0]    w_dist, w_best;

    // Pick the requester closest after rr_ptr on the ring (distance 0 = rr_ptr+1).
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_best = 32'(NUM_REQ);
        w_dist = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_dist = (i > 32'(r_rr_ptr)) ? i - 32'(r_rr_ptr) - 32'd1
                                         : i + 32'(NUM_REQ) - 32'(r_rr_ptr) - 32'd1;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_any  = 1'b1;
                w_best = w_dist;
                w_sel  = IDW'(i);
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        dn_valid  = 1'b0;
        dn_instr  = 1'b0;
        dn_addr   = '0;
        dn_wdata  = '0;
        dn_wstrb  = '0;
        req_ready = '0;
        req_rdata = '0;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) w_next = ST_BUSY;
            end
            ST_BUSY: begin
                dn_valid = 1'b1;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (r_grant == IDW'(i)) begin
                        dn_instr = req_instr[i];
                        dn_addr  = req_addr[32*i +: 32];
                        dn_wdata = req_wdata[32*i +: 32];
                        dn_wstrb = req_wstrb[4*i +: 4];
                    end
                end
                // A real response in the limit cycle takes precedence over the watchdog.
                if (dn_ready || w_timeout) begin
                    w_done    = 1'b1;
                    w_next    = ST_IDLE;
                    req_rdata = dn_ready ? dn_rdata : 32'hDEAD_BEEF;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        req_ready[i] = (r_grant == IDW'(i));
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= IDW'(NUM_REQ - 1);
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && w_any) r_grant <= w_sel;
            if (w_done) r_rr_ptr <= r_grant;
        end
    end

    assign grant_id = r_grant;
    assign busy     = (r_state == ST_BUSY);

`ifdef PICO_MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] r_to_cnt;
    logic          r_timeout_err;

    assign w_timeout   = (r_state == ST_BUSY) && !dn_ready && (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != ST_BUSY) r_to_cnt <= '0;
            else if (!dn_ready)     r_to_cnt <= r_to_cnt + CW'(1);
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

endmodule
